coherence_control: RTL and testbench

COHERENCE_CONTROL -- requirements
Module: coherence_control

---
 rtl/coherence_control.sv | 184 ++++++++++++++++++
 tb/tb_coherence_control.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coherence_control                                                          |
// | Two-core snooping coherence arbiter in front of a single-ported RAM.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coherence_control #(
   parameter int CPUS = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [CPUS-1:0]       iREN,
   input  logic [CPUS-1:0][31:0] iaddr,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   input  logic [CPUS-1:0]       cctrans,
   input  logic [CPUS-1:0]       ccwrite,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0]       dwait,
   output logic [CPUS-1:0][31:0] iload,
   output logic [CPUS-1:0][31:0] dload,
   output logic [CPUS-1:0]       ccwait,
   output logic [CPUS-1:0]       ccinv,
   output logic [CPUS-1:0][31:0] ccsnoopaddr,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [31:0]           ramaddr,
   output logic [31:0]           ramstore,
   input  logic [31:0]           ramload,
   input  logic [1:0]            ramstate
);

   localparam logic [1:0] c_ACCESS = 2'd2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB    = 3'd1,
      INV   = 3'd2,
      SNOOP = 3'd3,
      C2C   = 3'd4,
      RAMRD = 3'd5,
      IF    = 3'd6
   } state_t;

   state_t     r_state;
   logic       r_g;
   logic       r_o;
   logic       r_last;

   state_t     w_next;
   logic [1:0] w_req;
   logic       w_pick;
   logic       w_access;

   assign w_access = (ramstate == c_ACCESS);

   // Highest class with any requester wins; a two-way tie goes to the core not served last.
   always_comb begin
      w_req  = 2'b00;
      w_next = IDLE;
      if (|dWEN) begin
         w_req  = dWEN;
         w_next = WB;
      end else if (|cctrans) begin
         w_req  = cctrans;
         w_next = INV;
      end else if (|dREN) begin
         w_req  = dREN;
         w_next = SNOOP;
      end else if (|iREN) begin
         w_req  = iREN;
         w_next = IF;
      end
      w_pick = (&w_req) ? ~r_last : w_req[1];
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_g     <= 1'b0;
         r_o     <= 1'b1;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_next != IDLE) begin
                  r_state <= w_next;
                  r_g     <= w_pick;
                  r_o     <= ~w_pick;
               end
            end
            WB: begin
               if (!dWEN[r_g]) begin
                  r_state <= IDLE;
               end else if (w_access) begin
                  r_state <= IDLE;
                  r_last  <= r_g;
               end
            end
            INV: begin
               r_state <= IDLE;
               r_last  <= r_g;
            end
            SNOOP: begin
               if (!dREN[r_g]) r_state <= IDLE;
               else            r_state <= ccwrite[r_o] ? C2C : RAMRD;
            end
            C2C, RAMRD: begin
               if (!dREN[r_g]) begin
                  r_state <= IDLE;
               end else if (w_access) begin
                  r_state <= IDLE;
                  r_last  <= r_g;
               end
            end
            IF: begin
               if (!iREN[r_g]) begin
                  r_state <= IDLE;
               end else if (w_access) begin
                  r_state <= IDLE;
                  r_last  <= r_g;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Wait pulses are gated by the live request so an abandoned access never completes.
   always_comb begin
      iwait       = '1;
      dwait       = '1;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iload       = {CPUS{ramload}};
      dload       = {CPUS{ramload}};
      case (r_state)
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[r_g];
            ramstore = dstore[r_g];
            if (w_access && dWEN[r_g]) dwait[r_g] = 1'b0;
         end
         INV: begin
            ccwait[r_o]      = 1'b1;
            ccinv[r_o]       = 1'b1;
            ccsnoopaddr[r_o] = daddr[r_g];
         end
         SNOOP: begin
            ccwait[r_o]      = 1'b1;
            ccsnoopaddr[r_o] = daddr[r_g];
         end
         C2C: begin
            ccwait[r_o] = 1'b1;
            dload[r_g]  = dstore[r_o];
            ramWEN      = 1'b1;
            ramaddr     = daddr[r_g];
            ramstore    = dstore[r_o];
            if (w_access && dREN[r_g]) dwait[r_g] = 1'b0;
         end
         RAMRD: begin
            ccwait[r_o] = 1'b1;
            ramREN      = 1'b1;
            ramaddr     = daddr[r_g];
            if (w_access && dREN[r_g]) dwait[r_g] = 1'b0;
         end
         IF: begin
            ramREN  = 1'b1;
            ramaddr = iaddr[r_g];
            if (w_access && iREN[r_g]) iwait[r_g] = 1'b0;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_coherence_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coherence_control                                                       |
// | Two-core request driver, latency-programmable RAM and transaction model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_coherence_control;

   localparam int K_NONE = 0;
   localparam int K_IF   = 1;
   localparam int K_RD   = 2;
   localparam int K_WB   = 3;
   localparam int K_TR   = 4;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] iaddr, daddr, dstore;
   logic [1:0]       iwait, dwait, ccwait, ccinv;
   logic [1:0][31:0] iload, dload, ccsnoopaddr;
   logic             ramREN, ramWEN;
   logic [31:0]      ramaddr, ramstore, ramload;
   logic [1:0]       ramstate;

   coherence_control #(.CPUS(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // RAM: BUSY for lat cycles of an enabled access, then ACCESS; ovr_en forces a state.
   logic [31:0] mem [0:1023];
   bit          written [0:1023];
   logic [31:0] ref_mem [0:1023];
   int          lat = 0;
   int          cnt = 0;
   logic        ovr_en = 1'b0;
   logic [1:0]  ovr_val = 2'd0;

   function automatic logic [31:0] seedv(int i);
      return (i * 32'h9E3779B9) ^ 32'h13572468;
   endfunction

   function automatic logic [31:0] memval(int i);
      return written[i] ? mem[i] : seedv(i);
   endfunction

   assign ramload  = written[ramaddr[11:2]] ? mem[ramaddr[11:2]] : seedv(int'(ramaddr[11:2]));
   assign ramstate = ovr_en ? ovr_val :
                     (ramREN | ramWEN) ? ((cnt >= lat) ? 2'd2 : 2'd1) : 2'd0;

   always @(posedge CLK) begin
      if ((ramREN | ramWEN) && ramstate == 2'd2) cnt <= 0;
      else if (ramREN | ramWEN)                  cnt <= cnt + 1;
      else                                       cnt <= 0;
      if (ramWEN && ramstate == 2'd2) begin
         mem[ramaddr[11:2]]     <= ramstore;
         written[ramaddr[11:2]] <= 1'b1;
      end
   end

   int          total = 0;
   int          bad = 0;
   int          ref_last = 1;

   int          kind [2];
   logic [31:0] raddr [2];
   logic [31:0] rdata [2];
   logic        dirty [2];
   logic        live [2];

   int          done_cyc [2];
   logic [31:0] obs [2];
   logic [31:0] obs_snp [2];
   int          ccw_cnt [2];
   int          ccw_last [2];
   int          order_q [$];
   int          ren_cnt, wen_cnt, dlow_cnt, inv_cnt;
   logic        bad_rw, bad_cc;

   function automatic int rank(int k);
      case (k)
         K_WB:    return 0;
         K_TR:    return 1;
         K_RD:    return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int dur(int k);
      case (k)
         K_TR:    return 1;
         K_RD:    return 2 + lat;
         default: return 1 + lat;
      endcase
   endfunction

   task automatic apply_req();
      for (int c = 0; c < 2; c++) begin
         iREN[c]    = live[c] && (kind[c] == K_IF);
         dREN[c]    = live[c] && (kind[c] == K_RD);
         dWEN[c]    = live[c] && (kind[c] == K_WB);
         cctrans[c] = live[c] && (kind[c] == K_TR);
         iaddr[c]   = raddr[c];
         daddr[c]   = raddr[c];
         dstore[c]  = rdata[c];
         ccwrite[c] = dirty[c];
      end
   endtask

   // Behaves like two caches: hold each request until its completion is seen, then drop it.
   task automatic run_pair();
      int   cyc;
      logic hit;
      logic drop [2];
      order_q.delete();
      ren_cnt = 0; wen_cnt = 0; dlow_cnt = 0; inv_cnt = 0;
      bad_rw = 1'b0; bad_cc = 1'b0;
      for (int c = 0; c < 2; c++) begin
         live[c] = (kind[c] != K_NONE);
         done_cyc[c] = -1; obs[c] = '0; obs_snp[c] = '0;
         ccw_cnt[c] = 0; ccw_last[c] = 0;
      end
      apply_req();
      @(posedge CLK);
      cyc = 0;
      while ((live[0] || live[1]) && cyc < 60) begin
         @(negedge CLK);
         cyc++;
         if (ramREN && ramWEN) bad_rw = 1'b1;
         if (ramREN) ren_cnt++;
         if (ramWEN) wen_cnt++;
         if (dwait != 2'b11) dlow_cnt++;
         if (ccinv != 2'b00) inv_cnt++;
         for (int c = 0; c < 2; c++) begin
            drop[c] = 1'b0;
            if (ccwait[c]) begin
               ccw_cnt[c]++;
               ccw_last[c] = cyc;
               if (!(kind[1-c] == K_RD || kind[1-c] == K_TR)) bad_cc = 1'b1;
            end
            if (live[c]) begin
               case (kind[c])
                  K_IF:       hit = !iwait[c];
                  K_RD, K_WB: hit = !dwait[c];
                  default:    hit = ccinv[1-c];
               endcase
               if (hit) begin
                  drop[c]     = 1'b1;
                  done_cyc[c] = cyc;
                  obs[c]      = (kind[c] == K_IF) ? iload[c] : dload[c];
                  obs_snp[c]  = ccsnoopaddr[1-c];
                  order_q.push_back(c);
               end
            end
         end
         @(posedge CLK);
         #1;
         for (int c = 0; c < 2; c++) if (drop[c]) live[c] = 1'b0;
         apply_req();
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      total++; if (iwait !== 2'b11) begin bad++; $display("FAIL reset_iwait got=%b want=11", iwait); end
      total++; if (dwait !== 2'b11) begin bad++; $display("FAIL reset_dwait got=%b want=11", dwait); end
      total++; if (ccwait !== 2'b00) begin bad++; $display("FAIL reset_ccwait got=%b want=00", ccwait); end
      total++; if (ccinv !== 2'b00) begin bad++; $display("FAIL reset_ccinv got=%b want=00", ccinv); end
      total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("FAIL reset_ramen got=%b%b want=00", ramREN, ramWEN); end
      total++; if (ramaddr !== 32'h0) begin bad++; $display("FAIL reset_ramaddr got=%h want=0", ramaddr); end
      total++; if (ramstore !== 32'h0) begin bad++; $display("FAIL reset_ramstore got=%h want=0", ramstore); end
      total++; if (ccsnoopaddr !== 64'h0) begin bad++; $display("FAIL reset_snoopaddr got=%h want=0", ccsnoopaddr); end
      total++; if (iload[1] !== memval(0)) begin bad++; $display("FAIL reset_iload got=%h want=%h", iload[1], memval(0)); end
      total++; if (dload[0] !== memval(0)) begin bad++; $display("FAIL reset_dload got=%h want=%h", dload[0], memval(0)); end
      @(posedge CLK); #1;
      nRST = 1'b1;
      ref_last = 1;
   endtask

   task automatic test_snoop_read();
      int got;
      lat = 0;
      kind[0] = K_RD; raddr[0] = 32'h100; rdata[0] = $urandom; dirty[0] = 1'b0;
      kind[1] = K_RD; raddr[1] = 32'h200; rdata[1] = $urandom; dirty[1] = 1'b0;
      run_pair();
      got = (order_q.size() > 0) ? order_q[0] : -1;
      total++; if (got !== 0) begin bad++; $display("FAIL snoop_first_core got=%0d want=0", got); end
      total++; if (done_cyc[0] !== 2) begin bad++; $display("FAIL snoop_core0_cycle got=%0d want=2", done_cyc[0]); end
      total++; if (done_cyc[1] !== 5) begin bad++; $display("FAIL snoop_core1_cycle got=%0d want=5", done_cyc[1]); end
      total++; if (obs[0] !== ref_mem[32'h100 >> 2]) begin bad++; $display("FAIL snoop_dload0 got=%h want=%h", obs[0], ref_mem[32'h100 >> 2]); end
      total++; if (obs[1] !== ref_mem[32'h200 >> 2]) begin bad++; $display("FAIL snoop_dload1 got=%h want=%h", obs[1], ref_mem[32'h200 >> 2]); end
      total++; if (ccw_cnt[1] !== 2 || ccw_last[1] !== 2) begin bad++; $display("FAIL snoop_ccwait1 got=%0d/%0d want=2/2", ccw_cnt[1], ccw_last[1]); end
      total++; if (ccw_cnt[0] !== 2 || ccw_last[0] !== 5) begin bad++; $display("FAIL snoop_ccwait0 got=%0d/%0d want=2/5", ccw_cnt[0], ccw_last[0]); end
      ref_last = 1;
   endtask

   task automatic test_ifetch();
      lat = 2;
      kind[0] = K_IF; raddr[0] = 32'h40; rdata[0] = '0; dirty[0] = 1'b0;
      kind[1] = K_NONE; dirty[1] = 1'b0;
      run_pair();
      total++; if (done_cyc[0] !== 3) begin bad++; $display("FAIL ifetch_cycle got=%0d want=3", done_cyc[0]); end
      total++; if (ren_cnt !== 3) begin bad++; $display("FAIL ifetch_ramren got=%0d want=3", ren_cnt); end
      total++; if (obs[0] !== ref_mem[16]) begin bad++; $display("FAIL ifetch_iload got=%h want=%h", obs[0], ref_mem[16]); end
      ref_last = 0;
   endtask

   task automatic test_c2c();
      lat = 1;
      kind[0] = K_RD;   raddr[0] = 32'h80; rdata[0] = $urandom; dirty[0] = 1'b0;
      kind[1] = K_NONE; raddr[1] = 32'h0;  rdata[1] = 32'hDEADBEEF; dirty[1] = 1'b1;
      run_pair();
      total++; if (done_cyc[0] !== 3) begin bad++; $display("FAIL c2c_cycle got=%0d want=3", done_cyc[0]); end
      total++; if (obs[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL c2c_dload got=%h want=deadbeef", obs[0]); end
      total++; if (wen_cnt !== 2 || ren_cnt !== 0) begin bad++; $display("FAIL c2c_ramen got=wen%0d/ren%0d want=2/0", wen_cnt, ren_cnt); end
      total++; if (memval(32) !== 32'hDEADBEEF) begin bad++; $display("FAIL c2c_ramwrite got=%h want=deadbeef", memval(32)); end
      ref_mem[32] = 32'hDEADBEEF;
      dirty[1] = 1'b0;
      ref_last = 0;
   endtask

   task automatic test_inv();
      lat = 0;
      kind[0] = K_NONE; dirty[0] = 1'b0;
      kind[1] = K_TR; raddr[1] = 32'h300; rdata[1] = $urandom; dirty[1] = 1'b0;
      run_pair();
      total++; if (done_cyc[1] !== 1) begin bad++; $display("FAIL inv_cycle got=%0d want=1", done_cyc[1]); end
      total++; if (obs_snp[1] !== 32'h300) begin bad++; $display("FAIL inv_snoopaddr got=%h want=300", obs_snp[1]); end
      total++; if (inv_cnt !== 1 || ccw_cnt[0] !== 1) begin bad++; $display("FAIL inv_pulse got=inv%0d/ccw%0d want=1/1", inv_cnt, ccw_cnt[0]); end
      total++; if (ren_cnt + wen_cnt !== 0) begin bad++; $display("FAIL inv_ram got=%0d want=0", ren_cnt + wen_cnt); end
      total++; if (dlow_cnt !== 0) begin bad++; $display("FAIL inv_dwait got=%0d want=0", dlow_cnt); end
      ref_last = 1;
   endtask

   task automatic test_not_ready();
      logic [31:0] d;
      d = $urandom;
      lat = 0; ovr_en = 1'b1; ovr_val = 2'd3;
      kind[0] = K_WB; raddr[0] = 32'h20; rdata[0] = d; live[0] = 1'b1;
      kind[1] = K_NONE; live[1] = 1'b0;
      apply_req();
      @(posedge CLK);
      for (int k = 0; k < 6; k++) begin
         ovr_val = (k < 2) ? 2'd3 : (k < 4) ? 2'd1 : 2'd0;
         @(negedge CLK);
         total++;
         if (ramWEN !== 1'b1 || ramaddr !== 32'h20 || dwait !== 2'b11) begin
            bad++; $display("FAIL hold_state%0d got=wen%b addr%h dwait%b want=1/20/11", ovr_val, ramWEN, ramaddr, dwait);
         end
      end
      ovr_en = 1'b0;
      #1;
      total++; if (dwait !== 2'b10) begin bad++; $display("FAIL hold_release_dwait got=%b want=10", dwait); end
      @(posedge CLK); #1;
      live[0] = 1'b0; apply_req();
      total++; if (memval(8) !== d) begin bad++; $display("FAIL hold_ramwrite got=%h want=%h", memval(8), d); end
      ref_mem[8] = d;
      ref_last = 0;
   endtask

   task automatic test_abort();
      lat = 10;
      kind[0] = K_IF; raddr[0] = 32'h44; live[0] = 1'b1;
      kind[1] = K_NONE; live[1] = 1'b0;
      apply_req();
      @(posedge CLK);
      @(negedge CLK);
      total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL abort_started got=%b want=1", ramREN); end
      @(posedge CLK); #1;
      live[0] = 1'b0; apply_req();
      @(negedge CLK);
      total++; if (iwait !== 2'b11) begin bad++; $display("FAIL abort_nopulse got=%b want=11", iwait); end
      @(negedge CLK);
      total++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin bad++; $display("FAIL abort_idle got=ren%b iwait%b want=0/11", ramREN, iwait); end
      lat = 0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_mid_wb();
      int k;
      lat = 6;
      kind[0] = K_WB; raddr[0] = 32'h24; rdata[0] = $urandom; live[0] = 1'b1; dirty[0] = 1'b0;
      kind[1] = K_IF; raddr[1] = 32'h48; live[1] = 1'b1; dirty[1] = 1'b0;
      apply_req();
      @(posedge CLK);
      @(negedge CLK);
      total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h24) begin bad++; $display("FAIL rstwb_grant got=wen%b ren%b addr%h want=1/0/24", ramWEN, ramREN, ramaddr); end
      nRST = 1'b0;
      #1;
      total++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 2'b11) begin bad++; $display("FAIL rstwb_async got=wen%b addr%h dwait%b want=0/0/11", ramWEN, ramaddr, dwait); end
      live[0] = 1'b0; apply_req();
      @(negedge CLK);
      total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("FAIL rstwb_held got=%b%b want=00", ramREN, ramWEN); end
      nRST = 1'b1;
      lat = 1;
      k = 0;
      while (k < 20) begin
         @(negedge CLK);
         k++;
         if (!iwait[1]) break;
      end
      total++; if (k !== 2) begin bad++; $display("FAIL rstwb_if_cycle got=%0d want=2", k); end
      total++; if (iload[1] !== ref_mem[18]) begin bad++; $display("FAIL rstwb_iload got=%h want=%h", iload[1], ref_mem[18]); end
      @(posedge CLK); #1;
      live[1] = 1'b0; apply_req();
      total++; if (memval(9) !== ref_mem[9]) begin bad++; $display("FAIL rstwb_nowrite got=%h want=%h", memval(9), ref_mem[9]); end
      ref_last = 1;
   endtask

   // Transaction-level model: priority/round-robin order, latency and data per completed request.
   task automatic test_random();
      int first, c, got, nreq, exp_cyc, werr;
      logic [31:0] ev;
      for (int it = 0; it < 40; it++) begin
         lat = $urandom_range(0, 3);
         for (int i = 0; i < 2; i++) begin
            kind[i]  = $urandom_range(0, 4);
            raddr[i] = 32'($urandom_range(0, 15)) << 2;
            rdata[i] = $urandom;
            dirty[i] = 1'($urandom_range(0, 1));
         end
         if (kind[0] == K_NONE && kind[1] == K_NONE) kind[0] = K_RD;
         nreq = ((kind[0] != K_NONE) ? 1 : 0) + ((kind[1] != K_NONE) ? 1 : 0);
         if (nreq == 1)                         first = (kind[0] != K_NONE) ? 0 : 1;
         else if (rank(kind[0]) != rank(kind[1])) first = (rank(kind[0]) < rank(kind[1])) ? 0 : 1;
         else                                   first = 1 - ref_last;
         run_pair();
         for (int idx = 0; idx < nreq; idx++) begin
            c = (idx == 0) ? first : 1 - first;
            exp_cyc = (idx == 0) ? dur(kind[c]) : dur(kind[first]) + 1 + dur(kind[c]);
            got = (order_q.size() > idx) ? order_q[idx] : -1;
            total++; if (got !== c) begin bad++; $display("FAIL rnd%0d_order%0d got=%0d want=%0d", it, idx, got, c); end
            total++; if (done_cyc[c] !== exp_cyc) begin bad++; $display("FAIL rnd%0d_cycle core%0d kind%0d got=%0d want=%0d", it, c, kind[c], done_cyc[c], exp_cyc); end
            case (kind[c])
               K_IF: begin
                  ev = ref_mem[raddr[c] >> 2];
                  total++; if (obs[c] !== ev) begin bad++; $display("FAIL rnd%0d_iload core%0d got=%h want=%h", it, c, obs[c], ev); end
               end
               K_RD: begin
                  ev = dirty[1-c] ? rdata[1-c] : ref_mem[raddr[c] >> 2];
                  total++; if (obs[c] !== ev) begin bad++; $display("FAIL rnd%0d_dload core%0d got=%h want=%h", it, c, obs[c], ev); end
                  ref_mem[raddr[c] >> 2] = ev;
               end
               K_WB: ref_mem[raddr[c] >> 2] = rdata[c];
               default: begin
                  total++; if (obs_snp[c] !== raddr[c]) begin bad++; $display("FAIL rnd%0d_snoopaddr core%0d got=%h want=%h", it, c, obs_snp[c], raddr[c]); end
               end
            endcase
            ref_last = c;
         end
         werr = 0;
         for (int w = 0; w < 16; w++) if (memval(w) !== ref_mem[w]) werr++;
         total++; if (werr !== 0) begin bad++; $display("FAIL rnd%0d_memory got=%0d_bad_words want=0", it, werr); end
         total++; if (bad_rw !== 1'b0 || bad_cc !== 1'b0) begin bad++; $display("FAIL rnd%0d_exclusion got=rw%b cc%b want=0/0", it, bad_rw, bad_cc); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = seedv(i);
      for (int c = 0; c < 2; c++) begin
         kind[c] = K_NONE; raddr[c] = '0; rdata[c] = '0; dirty[c] = 1'b0; live[c] = 1'b0;
      end
      apply_req();
      test_reset();
      test_snoop_read();
      test_ifetch();
      test_c2c();
      test_inv();
      test_not_ready();
      test_abort();
      test_reset_mid_wb();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
